lms_led_sequencer: RTL and testbench
====================================

Name: lms_led_sequencer

Overview:
- Avalon-MM slave that owns the board's 8 LED outputs and sequences them.
- Each LED is driven per a 2-bit mode: hardware status passthrough, forced on, shared blink, or pulse-stretched hardware status.
- A global software override and an enable sit above the per-LED modes.
- Sits on the lms_ctr system bus in place of a raw PIO; hardware status lines come from the transceiver datapath (PLL lock, FIFO activity, etc.).

Parameters:
- PRESCALE_RST, 24'd39999, reset value of PRESCALE register (tick period minus one, in clk cycles)
- BLINK_RST, 8'd249, reset value of BLINK_HALF register
- STRETCH_RST, 8'd49, reset value of STRETCH register

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational from address, zero wait states
- hw_status  in  8  asynchronous status sources, one per LED
- led_out  out  8  registered LED drive, 1 = lit

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset:
  - Registers: CTRL=0x1, SWVAL=0, MODE=0, PRESCALE=PRESCALE_RST, BLINK_HALF=BLINK_RST, STRETCH=STRETCH_RST.
  - Internal state: all counters 0, blink phase 0, synchronizers 0.
  - Outputs: led_out=0; readdata follows address (CTRL=0x1 at addr 0).
- Register map (write = chipselect & ~write_n; unused bits read 0, ignore writes):
  - 0 CTRL [0]=enable, [1]=sw_override
  - 1 SWVAL [7:0]
  - 2 MODE [15:0]; LED i uses bits [2i+1:2i]
  - 3 PRESCALE [23:0]
  - 4 BLINK_HALF [7:0]
  - 5 STRETCH [7:0]
  - 6 STATUS (RO): [7:0]=led_out, [8]=blink phase, [23:16]=synchronized hw_status
  - 7 reads 0
- Register writes take effect the next cycle.
- hw_status: 2-flop synchronizer per bit; rising-edge detect on the synchronized value (third flop).
- Tick generator:
  - prescale counter counts 0..PRESCALE; tick=1 for one cycle when counter==PRESCALE, then the counter clears.
  - PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE clears the counter in the same cycle.
- Blink:
  - blink counter increments on tick.
  - On a tick with counter==BLINK_HALF, phase toggles and the counter clears.
  - BLINK_HALF=0 toggles phase every tick.
  - A write to BLINK_HALF clears the counter; phase is unaffected.
- Stretch (per LED i):
  - A rising edge loads cnt_i=STRETCH; otherwise, on tick with cnt_i!=0, cnt_i decrements.
  - Rising edge and tick in the same cycle: the load wins.
  - Retrigger while counting reloads the counter.
  - Stretched output = sync_hw[i] | (cnt_i!=0). STRETCH=0 degenerates to passthrough.
- Mode per LED: 00 = sync_hw[i]; 01 = 1; 10 = blink phase; 11 = stretched output.
- led_out next value, priority order:
  - enable=0 → 0
  - else sw_override=1 → SWVAL
  - else per-mode result
- led_out is registered: 1 cycle after the internal cause (write, tick, or synchronized edge). hw_status to led_out in mode 00 = 3 cycles.
- enable=0 holds prescale, blink and stretch counters and phase at 0. On re-enable, counting restarts from 0.
- Stretch edge detection stays live under sw_override. Counters keep running under override so that clearing override shows the current state.

Decomposition:
- Package lms_led_pkg:
  - register address constants (CTRL..STATUS)
  - mode encoding constants (MODE_HW, MODE_ON, MODE_BLINK, MODE_STRETCH)
  - CTRL bit indices
- One natural sub-module: lms_led_stretch.
  - One instance per LED (generate loop).
  - Contains synchronizer, edge detect, down-counter and stretched output.
  - Inputs: tick, STRETCH, enable.

Test Plan:
- Reset, read addrs 0-6 → 0x1, 0, 0, PRESCALE_RST, BLINK_RST, STRETCH_RST, STATUS=0; led_out=0.
- MODE=0x0001 (LED0 on), others hw; hw_status=0x80 → led_out=0x81, bit7 appearing 3 cycles after the hw change.
- PRESCALE=1, BLINK_HALF=2, MODE=0x0002 → LED0 toggles every 6 clk (ticks every 2 clk, toggle every 3 ticks); STATUS[8] tracks the phase.
- PRESCALE=0, STRETCH=5, MODE=0x0003, 1-cycle pulse on hw_status[0] → LED0 high 6 cycles after the synchronizer. Retrigger at count 2 reloads 5 and extends.
- CTRL=0x3, SWVAL=0xA5 → led_out=0xA5 next cycle. CTRL=0x2 → led_out=0. CTRL=0x1 → mode outputs restored, blink restarting at phase 0.
- Assert reset_n mid-blink and mid-stretch → led_out=0 immediately (asynchronous); registers back to reset values; no glitch after release.

Source files
------------

// File: rtl/lms_led_pkg.sv
// Shared definitions for the LED sequencer: Avalon register addresses,
// per-LED mode encodings and CTRL bit positions.
package lms_led_pkg;

  localparam int NUM_LEDS = 8;

  localparam logic [2:0] ADDR_CTRL       = 3'd0;
  localparam logic [2:0] ADDR_SWVAL      = 3'd1;
  localparam logic [2:0] ADDR_MODE       = 3'd2;
  localparam logic [2:0] ADDR_PRESCALE   = 3'd3;
  localparam logic [2:0] ADDR_BLINK_HALF = 3'd4;
  localparam logic [2:0] ADDR_STRETCH    = 3'd5;
  localparam logic [2:0] ADDR_STATUS     = 3'd6;

  typedef enum logic [1:0] {
    MODE_HW      = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_STRETCH = 2'b11
  } led_mode_e;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_SW_OVERRIDE = 1;

endpackage

// File: rtl/lms_led_stretch.sv
// Per-LED hardware status conditioning: 2-flop synchronizer, rising-edge
// detect and a tick-driven down-counter that stretches short pulses.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   hw             raw asynchronous status input
//   tick           prescaler tick (one clk wide)
//   stretch        reload value for the stretch counter
//   enable         0 holds the counter at zero
//   sync_hw        synchronized status
//   stretched      sync_hw OR'd with "counter still running"
module lms_led_stretch (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hw,
  input  logic       tick,
  input  logic [7:0] stretch,
  input  logic       enable,
  output logic       sync_hw,
  output logic       stretched
);

  logic       meta;
  logic       sync_q;
  logic       prev_q;
  logic       rise;
  logic [7:0] cnt;

  // The third flop only serves the edge detector; sync_q is the clean value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta   <= hw;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

  // A fresh edge reloads even when a tick lands in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (!enable) begin
      cnt <= 8'd0;
    end else if (rise) begin
      cnt <= stretch;
    end else if (tick && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign sync_hw   = sync_q;
  assign stretched = sync_q | (cnt != 8'd0);

endmodule

// File: rtl/lms_led_sequencer.sv
// Avalon-MM slave driving the 8 board LEDs. Each LED follows a 2-bit mode
// (hw passthrough, on, shared blink, stretched hw); a global enable and a
// software override sit above the modes.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address, chipselect, write_n, writedata, readdata   Avalon-MM slave
//                  (readdata combinational, zero wait states)
//   hw_status      asynchronous status sources, one per LED
//   led_out        registered LED drive, 1 = lit
module lms_led_sequencer
  import lms_led_pkg::*;
#(
  parameter logic [23:0] PRESCALE_RST = 24'd39999,
  parameter logic [7:0]  BLINK_RST    = 8'd249,
  parameter logic [7:0]  STRETCH_RST  = 8'd49
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  hw_status,
  output logic [7:0]  led_out
);

  logic [1:0]  ctrl;
  logic [7:0]  swval;
  logic [15:0] mode;
  logic [23:0] prescale;
  logic [7:0]  blink_half;
  logic [7:0]  stretch;

  logic        wr;
  logic        enable;
  logic        sw_override;
  logic        tick;
  logic [23:0] pcnt;
  logic [7:0]  bcnt;
  logic        blink_phase;
  logic [7:0]  sync_hw;
  logic [7:0]  stretched;
  logic [7:0]  mode_out;
  logic [7:0]  led_next;
  logic        unused_wdata;

  assign wr            = chipselect & ~write_n;
  assign enable        = ctrl[CTRL_ENABLE];
  assign sw_override   = ctrl[CTRL_SW_OVERRIDE];
  assign unused_wdata  = ^writedata[31:24];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl       <= 2'b01;
      swval      <= 8'd0;
      mode       <= 16'd0;
      prescale   <= PRESCALE_RST;
      blink_half <= BLINK_RST;
      stretch    <= STRETCH_RST;
    end else if (wr) begin
      case (address)
        ADDR_CTRL:       ctrl       <= writedata[1:0];
        ADDR_SWVAL:      swval      <= writedata[7:0];
        ADDR_MODE:       mode       <= writedata[15:0];
        ADDR_PRESCALE:   prescale   <= writedata[23:0];
        ADDR_BLINK_HALF: blink_half <= writedata[7:0];
        ADDR_STRETCH:    stretch    <= writedata[7:0];
        default: ;
      endcase
    end
  end

  assign tick = enable && (pcnt == prescale);

  // Prescaler: a PRESCALE write restarts the period immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= 24'd0;
    end else if (!enable || tick || (wr && address == ADDR_PRESCALE)) begin
      pcnt <= 24'd0;
    end else begin
      pcnt <= pcnt + 24'd1;
    end
  end

  // Blink: a BLINK_HALF write restarts the half-period but keeps the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt        <= 8'd0;
      blink_phase <= 1'b0;
    end else if (!enable) begin
      bcnt        <= 8'd0;
      blink_phase <= 1'b0;
    end else if (wr && address == ADDR_BLINK_HALF) begin
      bcnt <= 8'd0;
    end else if (tick) begin
      if (bcnt == blink_half) begin
        bcnt        <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        bcnt <= bcnt + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
    lms_led_stretch u_stretch (
      .clk       (clk),
      .reset_n   (reset_n),
      .hw        (hw_status[g]),
      .tick      (tick),
      .stretch   (stretch),
      .enable    (enable),
      .sync_hw   (sync_hw[g]),
      .stretched (stretched[g])
    );
  end

  always_comb begin
    mode_out = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (led_mode_e'(mode[2*i +: 2]))
        MODE_HW:      mode_out[i] = sync_hw[i];
        MODE_ON:      mode_out[i] = 1'b1;
        MODE_BLINK:   mode_out[i] = blink_phase;
        MODE_STRETCH: mode_out[i] = stretched[i];
      endcase
    end
    led_next = mode_out;
    if (!enable) begin
      led_next = '0;
    end else if (sw_override) begin
      led_next = swval;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= 8'd0;
    end else begin
      led_out <= led_next;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:       readdata = {30'd0, ctrl};
      ADDR_SWVAL:      readdata = {24'd0, swval};
      ADDR_MODE:       readdata = {16'd0, mode};
      ADDR_PRESCALE:   readdata = {8'd0, prescale};
      ADDR_BLINK_HALF: readdata = {24'd0, blink_half};
      ADDR_STRETCH:    readdata = {24'd0, stretch};
      ADDR_STATUS:     readdata = {8'd0, sync_hw, 7'd0, blink_phase, led_out};
      default:         readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_lms_led_sequencer.sv
// Self-checking bench for lms_led_sequencer: directed scenarios with fixed
// expectations, then a randomized run compared cycle by cycle against a
// behavioural model of the register/LED rules.
module tb_lms_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  hw_status;
  logic [7:0]  led_out;

  int n_checks = 0;
  int n_pass   = 0;

  lms_led_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hw_status  (hw_status),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model state
  logic [31:0] m_ctrl, m_swval, m_mode, m_prescale, m_blink, m_stretch;
  int          m_pcnt, m_bcnt;
  bit          m_phase;
  logic [7:0]  m_led;
  int          m_scnt [8];
  logic [7:0]  m_hist [3];   // hw_status as sampled 1, 2 and 3 edges ago

  task automatic model_reset();
    m_ctrl = 1; m_swval = 0; m_mode = 0;
    m_prescale = 39999; m_blink = 249; m_stretch = 49;
    m_pcnt = 0; m_bcnt = 0; m_phase = 0; m_led = 0;
    for (int i = 0; i < 8; i++) m_scnt[i] = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = 0;
  endtask

  task automatic model_step();
    bit         en, ovr, tick, wr;
    logic [7:0] sync, prev, nled;
    int         md;
    en   = m_ctrl[0];
    ovr  = m_ctrl[1];
    tick = en && (m_pcnt == int'(m_prescale));
    wr   = chipselect && !write_n;
    sync = m_hist[1];
    prev = m_hist[2];
    nled = 0;
    for (int i = 0; i < 8; i++) begin
      md = int'((m_mode >> (2*i)) & 3);
      case (md)
        0: nled[i] = sync[i];
        1: nled[i] = 1'b1;
        2: nled[i] = m_phase;
        default: nled[i] = sync[i] || (m_scnt[i] > 0);
      endcase
    end
    if (!en) nled = 0;
    else if (ovr) nled = m_swval[7:0];
    if (!en) begin
      m_pcnt = 0; m_bcnt = 0; m_phase = 0;
      for (int i = 0; i < 8; i++) m_scnt[i] = 0;
    end else begin
      if (tick || (wr && address == 3)) m_pcnt = 0; else m_pcnt++;
      if (wr && address == 4) m_bcnt = 0;
      else if (tick) begin
        if (m_bcnt == int'(m_blink)) begin m_phase = !m_phase; m_bcnt = 0; end
        else m_bcnt++;
      end
      for (int i = 0; i < 8; i++) begin
        if (sync[i] && !prev[i]) m_scnt[i] = int'(m_stretch);
        else if (tick && m_scnt[i] > 0) m_scnt[i]--;
      end
    end
    if (wr) begin
      case (address)
        0: m_ctrl     = writedata & 32'h3;
        1: m_swval    = writedata & 32'hFF;
        2: m_mode     = writedata & 32'hFFFF;
        3: m_prescale = writedata & 32'hFF_FFFF;
        4: m_blink    = writedata & 32'hFF;
        5: m_stretch  = writedata & 32'hFF;
        default: ;
      endcase
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = hw_status;
    m_led = nled;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return m_ctrl;
      3'd1: return m_swval;
      3'd2: return m_mode;
      3'd3: return m_prescale;
      3'd4: return m_blink;
      3'd5: return m_stretch;
      3'd6: return {8'd0, m_hist[1], 7'd0, m_phase, m_led};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: advance model on the edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led_out", {24'd0, led_out}, {24'd0, m_led});
    check("readdata", readdata, model_read(address));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic mid_reset();
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_led", {24'd0, led_out}, 32'd0);
    check("async_reset_ctrl", readdata, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_led", {24'd0, led_out}, 32'd0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] rst_vals [8];
    int          last, ntog, first, hi, r;
    bit          pbit;

    rst_vals = '{32'h1, 32'h0, 32'h0, 32'd39999, 32'd249, 32'd49, 32'h0, 32'h0};
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = 32'd0; hw_status = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_led", {24'd0, led_out}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1 check($sformatf("reset_read%0d", a), readdata, rst_vals[a]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    address = 3'd0;
    repeat (3) cycle();

    // LED0 forced on, hw_status[7] arrives three edges later
    wr(3'd2, 32'h1);
    hw_status = 8'h80;
    cycle(); check("hw_lat1", {24'd0, led_out}, 32'h01);
    cycle(); check("hw_lat2", {24'd0, led_out}, 32'h01);
    cycle(); check("hw_lat3", {24'd0, led_out}, 32'h81);
    hw_status = 8'h00;
    repeat (4) cycle();

    // Software override and enable priority
    wr(3'd1, 32'hA5);
    wr(3'd0, 32'h3);
    cycle(); check("sw_override", {24'd0, led_out}, 32'hA5);
    wr(3'd0, 32'h2);
    cycle(); check("disabled", {24'd0, led_out}, 32'h00);
    wr(3'd0, 32'h1);
    cycle(); check("reenabled", {24'd0, led_out}, 32'h01);

    // Blink: tick every 2 clk, toggle every 3 ticks
    wr(3'd0, 32'h0); wr(3'd3, 32'h1); wr(3'd4, 32'h2); wr(3'd2, 32'h2);
    wr(3'd0, 32'h1);
    last = -1; ntog = 0; first = -1; pbit = led_out[0];
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (led_out[0] != pbit) begin
        if (last >= 0) check("blink_period", c - last, 6);
        else first = c;
        last = c; ntog++; pbit = led_out[0];
      end
    end
    check("blink_toggles", ntog, 6);
    check("blink_first", first, 6);

    // Stretch: single pulse, then a retriggered pulse
    wr(3'd3, 32'h0); wr(3'd5, 32'h5); wr(3'd2, 32'h3);
    repeat (4) cycle();
    hi = 0;
    hw_status = 8'h01; cycle(); hi += int'(led_out[0]);
    hw_status = 8'h00;
    for (int c = 0; c < 15; c++) begin cycle(); hi += int'(led_out[0]); end
    check("stretch_len", hi, 6);
    hi = 0;
    hw_status = 8'h01; cycle(); hi += int'(led_out[0]);
    hw_status = 8'h00;
    repeat (3) begin cycle(); hi += int'(led_out[0]); end
    hw_status = 8'h01; cycle(); hi += int'(led_out[0]);
    hw_status = 8'h00;
    for (int c = 0; c < 15; c++) begin cycle(); hi += int'(led_out[0]); end
    check("stretch_retrig", hi, 10);

    // Reset in the middle of blinking and stretching
    wr(3'd4, 32'h1); wr(3'd2, 32'h0000_FFEE);
    hw_status = 8'hF0; cycle(); hw_status = 8'h00;
    repeat (3) cycle();
    mid_reset();
    repeat (5) cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2000) mid_reset();
      r = int'($urandom_range(0, 99));
      address = 3'($urandom_range(0, 7));
      writedata = $urandom;
      if (r < 15) begin
        chipselect = 1'b1; write_n = 1'b0;
        case (address)
          3'd0: writedata[0] = ($urandom_range(0, 9) != 0);
          3'd3: writedata[23:0] = 24'($urandom_range(0, 3));
          3'd4: writedata[7:0] = 8'($urandom_range(0, 3));
          3'd5: writedata[7:0] = 8'($urandom_range(0, 6));
          default: ;
        endcase
      end else if (r < 25) begin
        chipselect = 1'b1; write_n = 1'b1;
      end else begin
        chipselect = 1'b0; write_n = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 4) == 0) hw_status[$urandom_range(0, 7)] ^= 1'b1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
